trace_checker: RTL and testbench
================================

Name: trace_checker

Overview:
- Synthesizable self-check block for the naive_mips core.
- Compares architectural write events (GPR, HI, LO) from up to NUM_PORTS write ports per cycle, in program order, against an in-order expected-event stream buffered in an internal FIFO.
- Latches pass/fail with diagnostics, so directed CPU tests can run on FPGA without a simulator-side answer reader.
- Sits beside the CPU core: taps writeback/hilo write strobes; the expected stream comes from a ROM streamer.

Parameters:
- NUM_PORTS, 2, write ports observed per cycle; lower index = older in program order.
- DATA_W, 32, write data width.
- REG_ADDR_W, 5, GPR address width.
- EXP_DEPTH, 8, expected-event FIFO depth; power of 2, ≥ 2*NUM_PORTS.
- TIMEOUT_CYCLES, 4096, maximum RUN cycles without a matched event.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse: flush the FIFO, clear counters, enter RUN.
- wr_valid  in  NUM_PORTS  per-port write strobe.
- wr_kind  in  2*NUM_PORTS  per-port kind: 0=GPR, 1=HI, 2=LO, 3=reserved.
- wr_addr  in  REG_ADDR_W*NUM_PORTS  per-port GPR index; ignored for HI/LO.
- wr_data  in  DATA_W*NUM_PORTS  per-port written value.
- exp_valid  in  1  expected entry offered.
- exp_ready  out  1  FIFO can accept an entry.
- exp_kind  in  2  expected kind.
- exp_addr  in  REG_ADDR_W  expected GPR index.
- exp_data  in  DATA_W  expected value.
- exp_last  in  1  marks the final expected event.
- hold  out  1  request to freeze the CPU clock-enable; high in RUN when FIFO count < NUM_PORTS and the last entry is not yet buffered.
- done  out  1  state is PASS or FAIL.
- pass  out  1  state is PASS.
- fail_code  out  3  0 none, 1 kind/addr mismatch, 2 data mismatch, 3 starved, 4 timeout, 5 reserved kind.
- fail_port  out  clog2(NUM_PORTS)+1  port that failed.
- fail_got  out  DATA_W  offending written data.
- fail_exp  out  DATA_W  expected data at failure.
- match_count  out  32  events matched since start.

Behaviour:
Reset values:
- All outputs 0 except exp_ready = 1.
- State IDLE, FIFO empty.

States:
- IDLE: wait for start. Writes are ignored.
- RUN: the checking state.
- PASS and FAIL: sticky. start from any state re-enters RUN with an empty FIFO and cleared counters/diagnostics.

FIFO push:
- Push on exp_valid && exp_ready, accepted in IDLE and RUN.
- exp_ready = !full.
- Push and pop in the same cycle are legal.
- Pointers wrap modulo EXP_DEPTH.
- The start cycle flushes the FIFO and drops any push in that cycle.

Effective writes:
- A valid port with kind GPR and addr 0 is not an event and is skipped.
- Writes in the start cycle are ignored.
- Kind 3 → FAIL, code 5.

Checking in RUN, each cycle:
- Effective writes are compared against consecutive FIFO entries: head, head+1, … in ascending port order.
- GPR match requires kind, addr and data to be equal. HI/LO match requires kind and data to be equal.
- On the first non-matching port: FAIL.
  - Code 1 if kind or addr differ, else code 2.
  - fail_port, fail_got and fail_exp are latched.
  - No entries are popped that cycle.
- If the effective writes exceed the FIFO count: FAIL, code 3, fail_port = first unmatched port.
- If all ports match: pop k entries (k = effective write count) and add k to match_count.
- If a matched entry carries exp_last: PASS the next cycle. Later ports in the same cycle are ignored and not counted.

Timeout:
- A counter is cleared on any match or on start, and increments each RUN cycle without a match.
- Reaching TIMEOUT_CYCLES → FAIL, code 4.
- The counter freezes while hold=1.

Latency:
- Verdict registers update one clock after the offending write cycle.
- done/pass are registered.

Other rules:
- Reset asserted mid-run returns everything to reset values immediately (asynchronous).
- HI and LO written in the same cycle on two ports are checked in port order; the expected file lists hi before lo.

Decomposition:
- Package trace_checker_pkg:
  - ev_kind_t enum (GPR/HI/LO/RSVD).
  - fail_code_t enum.
  - exp_entry_t struct {kind, addr, data, last}.
  - state_t enum.
- Sub-module exp_fifo: a parametrised synchronous FIFO of exp_entry_t with multi-pop (0..NUM_PORTS per cycle) and a peek window of NUM_PORTS entries.

Test Plan:
- Preload 3 entries ($1=00000005, $2=0000000a, lo=00000032 last), start, then single-port writes in order → pass=1, match_count=3, fail_code=0.
- Same cycle: port0 $3=1, port1 $4=2, expected in that order → both matched; a swapped expected order → fail_code=1, fail_port=0.
- Expected $5=12345678, write $5=12345679 → fail_code=2, fail_got=12345679, fail_exp=12345678, state stays FAIL under later writes.
- Write $0=ffffffff, then $1=1 with expected only $1=1 last → pass=1, match_count=1.
- FIFO empty in RUN with a valid $2 write → fail_code=3; separately, no writes for TIMEOUT_CYCLES (param set to 16) → fail_code=4 at cycle 16.
- Assert rst_n low mid-run with 5 entries buffered → outputs at reset values; a subsequent start with a fresh 1-entry stream passes.

Source files
------------

// File: rtl/trace_checker_pkg.sv
// Shared types for the architectural write-trace checker.
// Expected-entry widths follow the naive_mips GPR file.
package trace_checker_pkg;

    localparam int EXP_DATA_W = 32;
    localparam int EXP_ADDR_W = 5;

    typedef enum logic [1:0] {
        EV_GPR  = 2'd0,
        EV_HI   = 2'd1,
        EV_LO   = 2'd2,
        EV_RSVD = 2'd3
    } ev_kind_t;

    typedef enum logic [2:0] {
        FC_NONE      = 3'd0,
        FC_KIND_ADDR = 3'd1,
        FC_DATA      = 3'd2,
        FC_STARVED   = 3'd3,
        FC_TIMEOUT   = 3'd4,
        FC_RSVD_KIND = 3'd5
    } fail_code_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PASS = 2'd2,
        ST_FAIL = 2'd3
    } state_t;

    typedef struct packed {
        ev_kind_t                kind;
        logic [EXP_ADDR_W-1:0]   addr;
        logic [EXP_DATA_W-1:0]   data;
        logic                    last;
    } exp_entry_t;

endpackage

// File: rtl/trace_checker_exp_fifo.sv
// Expected-event FIFO: one push per cycle, 0..NPOP pops per cycle,
// and a peek window exposing the NPOP oldest entries.
module exp_fifo
    import trace_checker_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NPOP  = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            push,
    input  exp_entry_t      push_entry,
    input  logic [CW-1:0]   pop_cnt,
    output logic            full,
    output logic [CW-1:0]   count,
    output exp_entry_t      peek [NPOP]
);

    exp_entry_t      mem_q [DEPTH];
    exp_entry_t      mem_d [DEPTH];
    logic [AW-1:0]   rd_q, rd_d;
    logic [AW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            do_push;

    assign full    = (cnt_q == CW'(DEPTH));
    assign count   = cnt_q;
    assign do_push = push && !full;

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (flush) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_entry;
                wr_d        = wr_q + 1'b1;
            end
            rd_d  = rd_q + AW'(pop_cnt);
            cnt_d = cnt_q + CW'(do_push) - pop_cnt;
        end
    end

    // Pointer arithmetic wraps naturally since DEPTH is a power of two.
    always_comb begin
        for (int i = 0; i < NPOP; i++) begin
            peek[i] = mem_q[rd_q + AW'(i)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/trace_checker.sv
// Compares in-order architectural writes (GPR/HI/LO) against a buffered
// expected-event stream and latches a sticky pass/fail verdict.
module trace_checker
    import trace_checker_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int DATA_W         = 32,
    parameter int REG_ADDR_W     = 5,
    parameter int EXP_DEPTH      = 8,
    parameter int TIMEOUT_CYCLES = 4096,
    localparam int PW = $clog2(NUM_PORTS) + 1,
    localparam int CW = $clog2(EXP_DEPTH) + 1,
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1),
    localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic [NUM_PORTS-1:0]           wr_valid,
    input  logic [2*NUM_PORTS-1:0]         wr_kind,
    input  logic [REG_ADDR_W*NUM_PORTS-1:0] wr_addr,
    input  logic [DATA_W*NUM_PORTS-1:0]    wr_data,
    input  logic                           exp_valid,
    output logic                           exp_ready,
    input  logic [1:0]                     exp_kind,
    input  logic [REG_ADDR_W-1:0]          exp_addr,
    input  logic [DATA_W-1:0]              exp_data,
    input  logic                           exp_last,
    output logic                           hold,
    output logic                           done,
    output logic                           pass,
    output logic [2:0]                     fail_code,
    output logic [PW-1:0]                  fail_port,
    output logic [DATA_W-1:0]              fail_got,
    output logic [DATA_W-1:0]              fail_exp,
    output logic [31:0]                    match_count
);

    state_t               state_q, state_d;
    fail_code_t           code_q, code_d;
    logic [PW-1:0]        port_q, port_d;
    logic [DATA_W-1:0]    got_q, got_d;
    logic [DATA_W-1:0]    expd_q, expd_d;
    logic [31:0]          mc_q, mc_d;
    logic [TW-1:0]        to_q, to_d;
    logic                 last_buf_q, last_buf_d;
    logic                 done_q, done_d;
    logic                 pass_q, pass_d;

    exp_entry_t           push_entry;
    exp_entry_t           peek [NUM_PORTS];
    exp_entry_t           ent;
    logic                 full, do_push;
    logic [CW-1:0]        count, pop_cnt, idx;
    ev_kind_t             w_kind;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]    w_data;
    fail_code_t           fc_w;
    logic                 stop, failed;

    assign push_entry = '{kind: ev_kind_t'(exp_kind), addr: exp_addr,
                          data: exp_data, last: exp_last};
    assign do_push    = exp_valid && !full && !start &&
                        (state_q == ST_IDLE || state_q == ST_RUN);

    exp_fifo #(
        .DEPTH (EXP_DEPTH),
        .NPOP  (NUM_PORTS)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (start),
        .push       (do_push),
        .push_entry (push_entry),
        .pop_cnt    (pop_cnt),
        .full       (full),
        .count      (count),
        .peek       (peek)
    );

    assign hold = (state_q == ST_RUN) && (count < CW'(NUM_PORTS)) && !last_buf_q;

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        port_d     = port_q;
        got_d      = got_q;
        expd_d     = expd_q;
        mc_d       = mc_q;
        to_d       = to_q;
        last_buf_d = last_buf_q || (do_push && exp_last);
        pop_cnt    = '0;
        idx        = '0;
        ent        = peek[0];
        w_kind     = EV_GPR;
        w_addr     = '0;
        w_data     = '0;
        fc_w       = FC_NONE;
        stop       = 1'b0;
        failed     = 1'b0;
        if (start) begin
            state_d    = ST_RUN;
            code_d     = FC_NONE;
            port_d     = '0;
            got_d      = '0;
            expd_d     = '0;
            mc_d       = '0;
            to_d       = '0;
            last_buf_d = 1'b0;
        end else if (state_q == ST_RUN) begin
            // idx counts matched entries so far: port i checks head+idx.
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_kind = ev_kind_t'(wr_kind[2*i +: 2]);
                w_addr = wr_addr[REG_ADDR_W*i +: REG_ADDR_W];
                w_data = wr_data[DATA_W*i +: DATA_W];
                ent    = peek[idx[IW-1:0]];
                fc_w   = FC_NONE;
                if (!stop && wr_valid[i] &&
                    !(w_kind == EV_GPR && w_addr == '0)) begin
                    if (w_kind == EV_RSVD) begin
                        fc_w = FC_RSVD_KIND;
                    end else if (idx >= count) begin
                        fc_w = FC_STARVED;
                    end else if (ent.kind != w_kind ||
                                 (w_kind == EV_GPR && ent.addr != w_addr)) begin
                        fc_w = FC_KIND_ADDR;
                    end else if (ent.data != w_data) begin
                        fc_w = FC_DATA;
                    end
                    if (fc_w != FC_NONE) begin
                        stop    = 1'b1;
                        failed  = 1'b1;
                        state_d = ST_FAIL;
                        code_d  = fc_w;
                        port_d  = PW'(i);
                        got_d   = w_data;
                        expd_d  = (fc_w == FC_KIND_ADDR || fc_w == FC_DATA)
                                  ? ent.data : '0;
                    end else begin
                        idx = idx + 1'b1;
                        if (ent.last) begin
                            stop    = 1'b1;
                            state_d = ST_PASS;
                        end
                    end
                end
            end
            if (!failed) begin
                pop_cnt = idx;
                mc_d    = mc_q + 32'(idx);
                if (idx != '0) begin
                    to_d = '0;
                end else if (!hold) begin
                    to_d = to_q + 1'b1;
                    if (to_d == TW'(TIMEOUT_CYCLES)) begin
                        state_d = ST_FAIL;
                        code_d  = FC_TIMEOUT;
                        port_d  = '0;
                        got_d   = '0;
                        expd_d  = '0;
                    end
                end
            end
        end
        done_d = (state_d == ST_PASS) || (state_d == ST_FAIL);
        pass_d = (state_d == ST_PASS);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            code_q     <= FC_NONE;
            port_q     <= '0;
            got_q      <= '0;
            expd_q     <= '0;
            mc_q       <= '0;
            to_q       <= '0;
            last_buf_q <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            port_q     <= port_d;
            got_q      <= got_d;
            expd_q     <= expd_d;
            mc_q       <= mc_d;
            to_q       <= to_d;
            last_buf_q <= last_buf_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign exp_ready   = !full;
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail_code   = code_q;
    assign fail_port   = port_q;
    assign fail_got    = got_q;
    assign fail_exp    = expd_q;
    assign match_count = mc_q;

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker with a queue-based reference model
// checked every cycle, plus literal expectations per scenario.
module tb_trace_checker;

    localparam int NP    = 2;
    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 8;
    localparam int TO    = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NP-1:0]     wr_valid = '0;
    logic [2*NP-1:0]   wr_kind = '0;
    logic [AW*NP-1:0]  wr_addr = '0;
    logic [DW*NP-1:0]  wr_data = '0;
    logic              exp_valid = 1'b0;
    logic              exp_ready;
    logic [1:0]        exp_kind = '0;
    logic [AW-1:0]     exp_addr = '0;
    logic [DW-1:0]     exp_data = '0;
    logic              exp_last = 1'b0;
    logic              hold, done, pass;
    logic [2:0]        fail_code;
    logic [1:0]        fail_port;
    logic [DW-1:0]     fail_got, fail_exp;
    logic [31:0]       match_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trace_checker #(
        .NUM_PORTS      (NP),
        .DATA_W         (DW),
        .REG_ADDR_W     (AW),
        .EXP_DEPTH      (DEPTH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .wr_valid    (wr_valid),
        .wr_kind     (wr_kind),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .exp_valid   (exp_valid),
        .exp_ready   (exp_ready),
        .exp_kind    (exp_kind),
        .exp_addr    (exp_addr),
        .exp_data    (exp_data),
        .exp_last    (exp_last),
        .hold        (hold),
        .done        (done),
        .pass        (pass),
        .fail_code   (fail_code),
        .fail_port   (fail_port),
        .fail_got    (fail_got),
        .fail_exp    (fail_exp),
        .match_count (match_count)
    );

    typedef struct {
        int          kind;
        int          addr;
        logic [31:0] data;
        bit          last;
    } ent_t;

    ent_t        q[$];
    int          m_state = 0;
    int          m_code = 0;
    int          m_port = 0;
    int          m_mc = 0;
    int          m_to = 0;
    logic [31:0] m_got = '0;
    logic [31:0] m_exp = '0;
    bit          m_lastbuf = 1'b0;

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0; m_code = 0; m_port = 0; m_mc = 0; m_to = 0;
        m_got = '0; m_exp = '0; m_lastbuf = 1'b0;
    endtask

    task automatic model_step();
        bit          can_push, hold_now, failed, passed;
        int          j, code, k, a;
        logic [31:0] d, ex;
        can_push = exp_valid && q.size() < DEPTH && m_state <= 1;
        if (start) begin
            model_reset();
            m_state = 1;
            return;
        end
        if (m_state == 1) begin
            hold_now = q.size() < NP && !m_lastbuf;
            j = 0; failed = 0; passed = 0;
            for (int p = 0; p < NP; p++) begin
                if (failed || passed) break;
                k = int'(wr_kind[2*p +: 2]);
                a = int'(wr_addr[AW*p +: AW]);
                d = wr_data[DW*p +: DW];
                if (!wr_valid[p] || (k == 0 && a == 0)) continue;
                code = 0; ex = '0;
                if (k == 3) code = 5;
                else if (j >= q.size()) code = 3;
                else begin
                    ex = q[j].data;
                    if (q[j].kind != k || (k == 0 && q[j].addr != a)) code = 1;
                    else if (q[j].data != d) code = 2;
                end
                if (code != 0) begin
                    failed = 1; m_state = 3; m_code = code; m_port = p;
                    m_got = d; m_exp = (code <= 2) ? ex : '0;
                end else begin
                    passed = q[j].last;
                    j++;
                end
            end
            if (!failed) begin
                repeat (j) void'(q.pop_front());
                m_mc += j;
                if (passed) m_state = 2;
                if (j > 0) m_to = 0;
                else if (!hold_now) begin
                    m_to++;
                    if (m_to == TO) begin
                        m_state = 3; m_code = 4; m_port = 0;
                        m_got = '0; m_exp = '0;
                    end
                end
            end
        end
        if (can_push) begin
            q.push_back('{int'(exp_kind), int'(exp_addr), exp_data, exp_last});
            if (exp_last) m_lastbuf = 1'b1;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        chk("exp_ready", exp_ready, q.size() < DEPTH);
        chk("hold", hold, m_state == 1 && q.size() < NP && !m_lastbuf);
        chk("done", done, m_state >= 2);
        chk("pass", pass, m_state == 2);
        chk("fail_code", fail_code, m_code);
        chk("fail_port", fail_port, m_port);
        chk("fail_got", fail_got, m_got);
        chk("fail_exp", fail_exp, m_exp);
        chk("match_count", match_count, m_mc);
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push(logic [1:0] k, logic [4:0] a, logic [31:0] d, logic l);
        exp_valid = 1'b1; exp_kind = k; exp_addr = a; exp_data = d; exp_last = l;
        @(negedge clk);
        exp_valid = 1'b0; exp_last = 1'b0;
    endtask

    task automatic wr(logic [1:0] v,
                      logic [1:0] k0, logic [4:0] a0, logic [31:0] d0,
                      logic [1:0] k1, logic [4:0] a1, logic [31:0] d1);
        wr_valid = v;
        wr_kind  = {k1, k0};
        wr_addr  = {a1, a0};
        wr_data  = {d1, d0};
        @(negedge clk);
        wr_valid = '0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_ready", exp_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_mc", match_count, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // three single-port writes against a 3-entry stream
        do_start();
        push(0, 1, 32'h5, 0);
        push(0, 2, 32'ha, 0);
        push(2, 0, 32'h32, 1);
        wr(2'b01, 0, 1, 32'h5, 0, 0, 0);
        wr(2'b01, 0, 2, 32'ha, 0, 0, 0);
        wr(2'b01, 2, 0, 32'h32, 0, 0, 0);
        chk("t1_pass", pass, 1);
        chk("t1_mc", match_count, 3);
        chk("t1_code", fail_code, 0);

        // dual-port in order
        do_start();
        push(0, 3, 32'h1, 0);
        push(0, 4, 32'h2, 1);
        wr(2'b11, 0, 3, 32'h1, 0, 4, 32'h2);
        chk("t2a_pass", pass, 1);
        chk("t2a_mc", match_count, 2);

        // dual-port against swapped expectation
        do_start();
        push(0, 4, 32'h2, 0);
        push(0, 3, 32'h1, 1);
        wr(2'b11, 0, 3, 32'h1, 0, 4, 32'h2);
        chk("t2b_code", fail_code, 1);
        chk("t2b_port", fail_port, 0);
        chk("t2b_got", fail_got, 32'h1);
        chk("t2b_exp", fail_exp, 32'h2);

        // last matched on port 0, port 1 ignored
        do_start();
        push(0, 3, 32'h1, 1);
        push(0, 4, 32'h2, 0);
        wr(2'b11, 0, 3, 32'h1, 0, 4, 32'h2);
        chk("t2c_pass", pass, 1);
        chk("t2c_mc", match_count, 1);

        // data mismatch, then sticky
        do_start();
        push(0, 5, 32'h12345678, 1);
        wr(2'b01, 0, 5, 32'h12345679, 0, 0, 0);
        chk("t3_code", fail_code, 2);
        chk("t3_got", fail_got, 32'h12345679);
        chk("t3_exp", fail_exp, 32'h12345678);
        wr(2'b01, 0, 5, 32'h12345678, 0, 0, 0);
        chk("t3_sticky", fail_code, 2);
        chk("t3_done", done, 1);

        // push during start dropped; $0 write skipped
        start = 1'b1;
        exp_valid = 1'b1; exp_kind = 0; exp_addr = 9; exp_data = 32'h9; exp_last = 1'b1;
        @(negedge clk);
        start = 1'b0; exp_valid = 1'b0; exp_last = 1'b0;
        push(0, 1, 32'h1, 1);
        wr(2'b01, 0, 0, 32'hffffffff, 0, 0, 0);
        wr(2'b01, 0, 1, 32'h1, 0, 0, 0);
        chk("t4_pass", pass, 1);
        chk("t4_mc", match_count, 1);

        // starved on empty FIFO
        do_start();
        wr(2'b01, 0, 2, 32'h7, 0, 0, 0);
        chk("t5a_code", fail_code, 3);
        chk("t5a_port", fail_port, 0);

        // starved on port 1
        do_start();
        push(0, 1, 32'h1, 0);
        wr(2'b11, 0, 1, 32'h1, 0, 2, 32'h2);
        chk("t5s_code", fail_code, 3);
        chk("t5s_port", fail_port, 1);
        chk("t5s_mc", match_count, 0);

        // reserved kind
        do_start();
        push(0, 1, 32'h1, 1);
        wr(2'b01, 3, 0, 32'hdead, 0, 0, 0);
        chk("t5r_code", fail_code, 5);

        // timeout after 16 un-held RUN cycles
        do_start();
        push(0, 1, 32'h1, 1);
        repeat (15) @(negedge clk);
        chk("t5b_notyet", done, 0);
        @(negedge clk);
        chk("t5b_done", done, 1);
        chk("t5b_code", fail_code, 4);

        // HI then LO in the same cycle
        do_start();
        push(1, 0, 32'haa, 0);
        push(2, 0, 32'hbb, 1);
        wr(2'b11, 1, 0, 32'haa, 2, 0, 32'hbb);
        chk("thl_pass", pass, 1);
        chk("thl_mc", match_count, 2);

        // fill to full, extra push dropped, start flushes
        do_start();
        for (int i = 0; i < 9; i++) push(0, 5'(i + 1), 32'(i), 0);
        chk("tf_full", exp_ready, 0);
        do_start();
        chk("tf_flush", exp_ready, 1);

        // asynchronous reset mid-run with entries buffered
        for (int i = 0; i < 5; i++) push(0, 5'(i + 1), 32'(i + 1), 0);
        wr(2'b01, 0, 1, 32'h1, 0, 0, 0);
        chk("tr_mc_pre", match_count, 1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("tr_ready", exp_ready, 1);
        chk("tr_mc", match_count, 0);
        chk("tr_done", done, 0);
        chk("tr_hold", hold, 0);
        rst_n = 1'b1;
        @(negedge clk);
        do_start();
        push(0, 7, 32'h9, 1);
        wr(2'b01, 0, 7, 32'h9, 0, 0, 0);
        chk("tr_pass", pass, 1);
        chk("tr_mc_post", match_count, 1);

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
